ps2_movement_keys: RTL

//  Receives PS/2 keyboard frames and keeps the held/released state of the four arrow keys.

---
 rtl/ps2_movement_keys.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_movement_keys.sv
// PS/2 keyboard receiver that tracks the held/released state of the four
// extended arrow keys and presents them as level signals to the player
// update stage. Raw pad signals are synchronized, the clock is glitch
// filtered, frames are checked for start/parity/stop, and a small decode
// FSM turns make/break byte sequences into key set/clear actions.
module ps2_movement_keys #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK
    } state_t;

    // Key vector order: {right, left, forward, backward}
    localparam int KEY_RIGHT    = 3;
    localparam int KEY_LEFT     = 2;
    localparam int KEY_FORWARD  = 1;
    localparam int KEY_BACKWARD = 0;

    logic          clk_meta_q, clk_meta_d;
    logic          clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d;
    logic          dat_sync_q, dat_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   shift_q, shift_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_error_q, frame_error_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [10:0]   frame;
    logic          frame_good;

    state_t        state_q, state_d;
    logic [3:0]    keys_q, keys_d;
    logic [3:0]    key_hit;

    // Two-flop synchronizers; clock and data idle high on the PS/2 bus.
    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2_dat;
        dat_sync_d = dat_meta_q;
    end

    // Glitch filter: the filtered clock follows the synchronized clock only
    // after FILTER_LEN consecutive differing samples; a falling transition of
    // the filtered level is the bit strobe.
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        strobe     = 1'b0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
                strobe     = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    // Frame assembly: bits shift in LSB first; the 11th strobe judges the
    // whole frame, and a stalled partial frame is dropped after the timeout.
    always_comb begin
        frame         = {dat_sync_q, shift_q[10:1]};
        frame_good    = ~frame[0] & frame[10] & (^frame[9:1]);
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        idle_cnt_d    = idle_cnt_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        rx_byte_d     = rx_byte_q;
        if (strobe) begin
            idle_cnt_d = '0;
            shift_d    = frame;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (frame_good) begin
                    byte_valid_d = 1'b1;
                    rx_byte_d    = frame[8:1];
                end else begin
                    frame_error_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d     = '0;
                idle_cnt_d    = '0;
                frame_error_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TW'(1);
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    // Map a received scan code to its arrow-key bit (zero for other codes).
    always_comb begin
        key_hit = 4'b0000;
        case (rx_byte_q)
            8'h74:   key_hit[KEY_RIGHT]    = 1'b1;
            8'h6B:   key_hit[KEY_LEFT]     = 1'b1;
            8'h75:   key_hit[KEY_FORWARD]  = 1'b1;
            8'h72:   key_hit[KEY_BACKWARD] = 1'b1;
            default: key_hit = 4'b0000;
        endcase
    end

    // Decode FSM next state and key updates; a frame error or timeout
    // abandons any partially received prefix without touching the keys.
    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        if (frame_error_q) begin
            state_d = IDLE;
        end else if (byte_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte_q == 8'hE0) begin
                        state_d = EXT;
                    end else if (rx_byte_q == 8'hF0) begin
                        state_d = BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXT: begin
                    if (rx_byte_q == 8'hF0) begin
                        state_d = EXTBRK;
                    end else begin
                        keys_d  = keys_q | key_hit;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                end
                EXTBRK: begin
                    keys_d  = keys_q & ~key_hit;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register for the whole receiver.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta_q    <= 1'b1;
            clk_sync_q    <= 1'b1;
            dat_meta_q    <= 1'b1;
            dat_sync_q    <= 1'b1;
            filt_clk_q    <= 1'b1;
            filt_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            idle_cnt_q    <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            rx_byte_q     <= 8'h00;
            state_q       <= IDLE;
            keys_q        <= 4'b0000;
        end else begin
            clk_meta_q    <= clk_meta_d;
            clk_sync_q    <= clk_sync_d;
            dat_meta_q    <= dat_meta_d;
            dat_sync_q    <= dat_sync_d;
            filt_clk_q    <= filt_clk_d;
            filt_cnt_q    <= filt_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            idle_cnt_q    <= idle_cnt_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
            rx_byte_q     <= rx_byte_d;
            state_q       <= state_d;
            keys_q        <= keys_d;
        end
    end

    assign turn_right    = keys_q[KEY_RIGHT];
    assign turn_left     = keys_q[KEY_LEFT];
    assign move_forward  = keys_q[KEY_FORWARD];
    assign move_backward = keys_q[KEY_BACKWARD];
    assign byte_valid    = byte_valid_q;
    assign rx_byte       = rx_byte_q;
    assign frame_error   = frame_error_q;

endmodule
